// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fifo.sv
// fifo: circular-buffer FIFO with show-ahead head and occupancy count
module fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    rd_d = pop ? (rd_q == LAST ? '0 : rd_q + AW'(1)) : rd_q;
    wr_d = push ? (wr_q == LAST ? '0 : wr_q + AW'(1)) : wr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    head = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order fetch stage; issues word requests and pushes {pc, instr} to the fetch queue.
// Define FETCH_BYPASS_EN to let a response skip an empty skid buffer straight into the queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fq_write_en,
  output logic [63:0] fq_write_data,
  input  logic        fq_full
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_OUTSTANDING);
  logic [31:0] pc_q, pc_d, pcq_head;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, skid_cnt, pcq_cnt_unused;
  logic [1:0] rpc_unused;
  fetch_entry_t skid_head, rsp_entry;
  logic flush, req_fire, keep, bypass, skid_ne, skid_pop, skid_push;
  always_comb begin
    flush = reset | redirect_valid;
    rpc_unused = redirect_pc[1:0];
    imem_req_valid = !reset && !redirect_valid && ({1'b0, out_q} + {1'b0, skid_cnt} < CREDITS);
    imem_req_addr = pc_q;
    req_fire = imem_req_valid && imem_req_ready;
    keep = imem_rsp_valid && drop_q == '0 && !redirect_valid;
    rsp_entry = '{pc: pcq_head, instr: imem_rsp_data};
    skid_ne = skid_cnt != '0;
    skid_pop = skid_ne && !fq_full && !redirect_valid && !reset;
`ifdef FETCH_BYPASS_EN
    bypass = keep && !skid_ne && !fq_full && !reset;
`else
    bypass = 1'b0;
`endif
    skid_push = keep && !bypass;
    fq_write_en = skid_pop || bypass;
    fq_write_data = !fq_write_en ? '0 : skid_ne ? skid_head : rsp_entry;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : req_fire ? pc_q + 32'(INSTR_BYTES) : pc_q;
    out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    // every response still in flight at a redirect belongs to the old path
    drop_d = redirect_valid ? out_q - CW'(imem_rsp_valid)
           : (imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fifo #(.T(fetch_entry_t), .DEPTH(MAX_OUTSTANDING)) u_skid (
    .clk(clk), .rst(flush), .push(skid_push), .push_data(rsp_entry),
    .pop(skid_pop), .head(skid_head), .count(skid_cnt)
  );
  fifo #(.T(logic [31:0]), .DEPTH(MAX_OUTSTANDING)) u_pcq (
    .clk(clk), .rst(flush), .push(req_fire), .push_data(pc_q),
    .pop(keep), .head(pcq_head), .count(pcq_cnt_unused)
  );
endmodule
